// File: rtl/decode_queue.sv
// Decode queue: decodes RV32I instruction words offered by fetch, samples the
// register-file read data in the same cycle, and holds the decoded entries in a
// small FIFO of DEPTH entries for the AGEX stage.
// Optional feature macro: DECODE_QUEUE_M_EXT_EN (accept the RV32M multiply/divide group).
// Field encodings (INST_OP_*, ALU_OP_*, DATA_SIZE_*, *_EXTEND) are defined locally below.
module decode_queue #(
    parameter int PC_WIDTH = 16,
    parameter int DEPTH    = 2,
    localparam int INST_OP_WIDTH     = 4,
    localparam int ALU_OP_WIDTH      = 5,
    localparam int DATA_SIZE_WIDTH   = 2,
    localparam int EXTEND_TYPE_WIDTH = 1,
    localparam int CNT_W             = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PC_WIDTH-1:0]          in_pc,
    input  logic [31:0]                  in_inst,
    input  logic                         flush,
    output logic [4:0]                   rs1_num,
    output logic [4:0]                   rs2_num,
    input  logic [31:0]                  rs1_data,
    input  logic [31:0]                  rs2_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [31:0]                  out_rs1,
    output logic [31:0]                  out_rs2,
    output logic [31:0]                  out_imm,
    output logic [4:0]                   out_drnum,
    output logic                         out_reg_we,
    output logic [INST_OP_WIDTH-1:0]     out_inst_op,
    output logic [ALU_OP_WIDTH-1:0]      out_alu_op,
    output logic [DATA_SIZE_WIDTH-1:0]   out_data_size,
    output logic [EXTEND_TYPE_WIDTH-1:0] out_extend_type,
    output logic                         out_illegal,
    output logic [CNT_W-1:0]             count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [INST_OP_WIDTH-1:0] INST_OP_INVALID = 4'd0, INST_OP_ALU_R = 4'd1,
        INST_OP_ALU_I = 4'd2, INST_OP_LOAD = 4'd3, INST_OP_STORE = 4'd4, INST_OP_BRANCH = 4'd5,
        INST_OP_JAL = 4'd6, INST_OP_JALR = 4'd7, INST_OP_LUI = 4'd8, INST_OP_AUIPC = 4'd9;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_INVALID = 5'd0, ALU_OP_ADD = 5'd1, ALU_OP_SUB = 5'd2,
        ALU_OP_SLL = 5'd3, ALU_OP_SLT = 5'd4, ALU_OP_SLTU = 5'd5, ALU_OP_XOR = 5'd6,
        ALU_OP_SRL = 5'd7, ALU_OP_SRA = 5'd8, ALU_OP_OR = 5'd9, ALU_OP_AND = 5'd10,
        ALU_OP_BEQ = 5'd11, ALU_OP_BNE = 5'd12, ALU_OP_BLT = 5'd13, ALU_OP_BGE = 5'd14,
        ALU_OP_BLTU = 5'd15, ALU_OP_BGEU = 5'd16;
`ifdef DECODE_QUEUE_M_EXT_EN
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL = 5'd17, ALU_OP_MULH = 5'd18,
        ALU_OP_MULHSU = 5'd19, ALU_OP_MULHU = 5'd20, ALU_OP_DIV = 5'd21, ALU_OP_DIVU = 5'd22,
        ALU_OP_REM = 5'd23, ALU_OP_REMU = 5'd24;
`endif

    localparam logic [DATA_SIZE_WIDTH-1:0] DATA_SIZE_BYTE = 2'd0, DATA_SIZE_HALF = 2'd1,
        DATA_SIZE_WORD = 2'd2;
    localparam logic [EXTEND_TYPE_WIDTH-1:0] ZERO_EXTEND = 1'b0, SIGN_EXTEND = 1'b1;

    typedef struct packed {
        logic [PC_WIDTH-1:0]          pc;
        logic [31:0]                  rs1;
        logic [31:0]                  rs2;
        logic [31:0]                  imm;
        logic [4:0]                   drnum;
        logic                         reg_we;
        logic [INST_OP_WIDTH-1:0]     inst_op;
        logic [ALU_OP_WIDTH-1:0]      alu_op;
        logic [DATA_SIZE_WIDTH-1:0]   data_size;
        logic [EXTEND_TYPE_WIDTH-1:0] extend_type;
        logic                         illegal;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            dec;
    entry_t            head;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // alt selects SUB/SRA over ADD/SRL
    function automatic logic [ALU_OP_WIDTH-1:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001:  return ALU_OP_SLL;
            3'b010:  return ALU_OP_SLT;
            3'b011:  return ALU_OP_SLTU;
            3'b100:  return ALU_OP_XOR;
            3'b101:  return alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  return ALU_OP_OR;
            default: return ALU_OP_AND;
        endcase
    endfunction

    // Combinational decode of the offered word, including register-file addressing
    always_comb begin
        logic [2:0] f3;
        logic [6:0] f7;
        logic       legal, wr, use1, use2;
        f3    = in_inst[14:12];
        f7    = in_inst[31:25];
        legal = 1'b1;
        wr    = 1'b0;
        use1  = 1'b0;
        use2  = 1'b0;
        dec   = '0;
        dec.pc = in_pc;
        case (in_inst[6:0])
            7'b0110111: begin dec.inst_op = INST_OP_LUI; dec.alu_op = ALU_OP_ADD; wr = 1'b1;
                              dec.imm = {in_inst[31:12], 12'b0}; end
            7'b0010111: begin dec.inst_op = INST_OP_AUIPC; dec.alu_op = ALU_OP_ADD; wr = 1'b1;
                              dec.imm = {in_inst[31:12], 12'b0}; end
            7'b1101111: begin dec.inst_op = INST_OP_JAL; dec.alu_op = ALU_OP_ADD; wr = 1'b1;
                              dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                         in_inst[20], in_inst[30:21], 1'b0}; end
            7'b1100111: begin dec.inst_op = INST_OP_JALR; dec.alu_op = ALU_OP_ADD; wr = 1'b1;
                              use1 = 1'b1; dec.imm = {{20{in_inst[31]}}, in_inst[31:20]}; end
            7'b1100011: begin
                dec.inst_op = INST_OP_BRANCH;
                use1 = 1'b1;
                use2 = 1'b1;
                dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
                case (f3)
                    3'b000:  dec.alu_op = ALU_OP_BEQ;
                    3'b001:  dec.alu_op = ALU_OP_BNE;
                    3'b100:  dec.alu_op = ALU_OP_BLT;
                    3'b101:  dec.alu_op = ALU_OP_BGE;
                    3'b110:  dec.alu_op = ALU_OP_BLTU;
                    3'b111:  dec.alu_op = ALU_OP_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                dec.inst_op = INST_OP_LOAD;
                dec.alu_op  = ALU_OP_ADD;
                wr   = 1'b1;
                use1 = 1'b1;
                dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
                dec.data_size   = (f3[1:0] == 2'b00) ? DATA_SIZE_BYTE :
                                  (f3[1:0] == 2'b01) ? DATA_SIZE_HALF : DATA_SIZE_WORD;
                dec.extend_type = f3[2] ? ZERO_EXTEND : SIGN_EXTEND;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) legal = 1'b0;
            end
            7'b0100011: begin
                dec.inst_op = INST_OP_STORE;
                dec.alu_op  = ALU_OP_ADD;
                use1 = 1'b1;
                use2 = 1'b1;
                dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                dec.data_size = (f3[1:0] == 2'b00) ? DATA_SIZE_BYTE :
                                (f3[1:0] == 2'b01) ? DATA_SIZE_HALF : DATA_SIZE_WORD;
                if (f3 >= 3'b011) legal = 1'b0;
            end
            7'b0010011: begin
                dec.inst_op = INST_OP_ALU_I;
                wr   = 1'b1;
                use1 = 1'b1;
                dec.imm    = {{20{in_inst[31]}}, in_inst[31:20]};
                dec.alu_op = alu_base(f3, (f3 == 3'b101) && f7[5]);
                if (f3 == 3'b001 && f7 != 7'b0000000) legal = 1'b0;
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) legal = 1'b0;
            end
            7'b0110011: begin
                dec.inst_op = INST_OP_ALU_R;
                wr   = 1'b1;
                use1 = 1'b1;
                use2 = 1'b1;
                if (f7 == 7'b0000000) dec.alu_op = alu_base(f3, 1'b0);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    dec.alu_op = alu_base(f3, 1'b1);
`ifdef DECODE_QUEUE_M_EXT_EN
                else if (f7 == 7'b0000001) begin
                    case (f3)
                        3'b000:  dec.alu_op = ALU_OP_MUL;
                        3'b001:  dec.alu_op = ALU_OP_MULH;
                        3'b010:  dec.alu_op = ALU_OP_MULHSU;
                        3'b011:  dec.alu_op = ALU_OP_MULHU;
                        3'b100:  dec.alu_op = ALU_OP_DIV;
                        3'b101:  dec.alu_op = ALU_OP_DIVU;
                        3'b110:  dec.alu_op = ALU_OP_REM;
                        default: dec.alu_op = ALU_OP_REMU;
                    endcase
                end
`endif
                else legal = 1'b0;
            end
            7'b0001111, 7'b1110011: legal = 1'b0;
            default:                legal = 1'b0;
        endcase
        // Illegal words still travel down the queue, but never write a register
        if (!legal) begin
            dec.inst_op = INST_OP_INVALID;
            dec.alu_op  = ALU_OP_INVALID;
        end
        dec.illegal = !legal;
        dec.reg_we  = wr && legal && (in_inst[11:7] != 5'd0);
        dec.drnum   = dec.reg_we ? in_inst[11:7] : 5'd0;
        rs1_num     = use1 ? in_inst[19:15] : 5'd0;
        rs2_num     = use2 ? in_inst[24:20] : 5'd0;
        dec.rs1     = use1 ? rs1_data : 32'd0;
        dec.rs2     = use2 ? rs2_data : 32'd0;
    end

    assign in_ready = rst_n && !flush && (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && out_ready;

    // Next pointer/occupancy; flush empties the queue and wins over a pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = ptr_next(tail_q);
            if (pop)  head_d = ptr_next(head_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer and occupancy registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; stale contents are hidden because occupancy gates the outputs
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= dec;
    end

    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign head      = out_valid ? mem_q[head_q] : '0;

    assign out_pc          = head.pc;
    assign out_rs1         = head.rs1;
    assign out_rs2         = head.rs2;
    assign out_imm         = head.imm;
    assign out_drnum       = head.drnum;
    assign out_reg_we      = head.reg_we;
    assign out_inst_op     = head.inst_op;
    assign out_alu_op      = head.alu_op;
    assign out_data_size   = head.data_size;
    assign out_extend_type = head.extend_type;
    assign out_illegal     = head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2, PC_WIDTH=16).
// Expected encodings: INST_OP ALU_R=1 ALU_I=2 LOAD=3 STORE=4 LUI=8 INVALID=0;
// ALU_OP ADD=1 SUB=2 MUL=17 INVALID=0; DATA_SIZE_WORD=2; SIGN_EXTEND=1.
module tb_decode_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic [4:0]  rs1_num, rs2_num;
    logic [31:0] rs1_data, rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [31:0] out_rs1, out_rs2, out_imm;
    logic [4:0]  out_drnum;
    logic        out_reg_we;
    logic [3:0]  out_inst_op;
    logic [4:0]  out_alu_op;
    logic [1:0]  out_data_size;
    logic [0:0]  out_extend_type;
    logic        out_illegal;
    logic [1:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    decode_queue #(.PC_WIDTH(16), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .rs1_num(rs1_num), .rs2_num(rs2_num), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_drnum(out_drnum),
        .out_reg_we(out_reg_we), .out_inst_op(out_inst_op), .out_alu_op(out_alu_op),
        .out_data_size(out_data_size), .out_extend_type(out_extend_type),
        .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction with the consumer stalled, leaving it at the tail
    task automatic push_one(input logic [31:0] inst, input logic [15:0] pc);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0;
        rs1_data = '0; rs2_data = '0; out_ready = 1'b0;

        // reset
        tick();
        tick();
        check("rst_count", count, 0);
        check("rst_valid", out_valid, 0);
        check("rst_imm", out_imm, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("first_in_ready", in_ready, 1);

        // addi x1,x0,5 with consumer ready
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 16'h0010; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("addi_valid", out_valid, 1);
        check("addi_alu", out_alu_op, 1);
        check("addi_imm", out_imm, 5);
        check("addi_drnum", out_drnum, 1);
        check("addi_we", out_reg_we, 1);
        check("addi_op", out_inst_op, 2);
        drain_one();
        check("addi_gone", out_valid, 0);
        check("empty_imm_zero", out_imm, 0);

        // sub then lw, consumer stalled
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h402081B3; in_pc = 16'h0020;
        rs1_data = 32'hDEADBEEF; rs2_data = 32'h12345678;
        #1;
        check("sub_rs1_num", rs1_num, 1);
        check("sub_rs2_num", rs2_num, 2);
        tick();
        in_inst = 32'h0000A103; in_pc = 16'h0024;
        rs1_data = 32'hCAFE0000; rs2_data = 32'h55555555;
        #1;
        check("lw_rs2_num", rs2_num, 0);
        tick();
        in_inst = 32'h00000013; in_pc = 16'h0099;
        check("full_count", count, 2);
        check("full_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        check("full_no_push", count, 2);
        check("sub_pc", out_pc, 16'h0020);
        check("sub_alu", out_alu_op, 2);
        check("sub_rs1", out_rs1, 32'hDEADBEEF);
        check("sub_rs2", out_rs2, 32'h12345678);
        check("sub_drnum", out_drnum, 3);
        drain_one();
        check("lw_pc", out_pc, 16'h0024);
        check("lw_size", out_data_size, 2);
        check("lw_imm", out_imm, 0);
        check("lw_ext", out_extend_type, 1);
        check("lw_drnum", out_drnum, 2);
        check("lw_rs1", out_rs1, 32'hCAFE0000);
        check("lw_rs2_unused", out_rs2, 0);
        check("lw_count", count, 1);
        drain_one();
        check("lw_gone", out_valid, 0);

        // ecall is illegal
        push_one(32'h00000073, 16'h0030);
        check("ecall_valid", out_valid, 1);
        check("ecall_illegal", out_illegal, 1);
        check("ecall_we", out_reg_we, 0);
        check("ecall_drnum", out_drnum, 0);
        check("ecall_alu", out_alu_op, 0);
        check("ecall_op", out_inst_op, 0);
        drain_one();

        // mul x3,x1,x2
        push_one(32'h022081B3, 16'h0034);
`ifdef DECODE_QUEUE_M_EXT_EN
        check("mul_alu", out_alu_op, 17);
        check("mul_illegal", out_illegal, 0);
        check("mul_we", out_reg_we, 1);
`else
        check("mul_illegal", out_illegal, 1);
        check("mul_we", out_reg_we, 0);
        check("mul_alu", out_alu_op, 0);
`endif
        drain_one();

        // lui x1,0x12345: rs1 field is nonzero but unused
        in_inst = 32'h123450B7;
        #1;
        check("lui_rs1_num", rs1_num, 0);
        push_one(32'h123450B7, 16'h0038);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_drnum", out_drnum, 1);
        check("lui_op", out_inst_op, 8);
        drain_one();

        // sw x2,8(x1)
        in_inst = 32'h0020A423;
        #1;
        check("sw_rs2_num", rs2_num, 2);
        push_one(32'h0020A423, 16'h003C);
        check("sw_imm", out_imm, 8);
        check("sw_we", out_reg_we, 0);
        check("sw_size", out_data_size, 2);
        check("sw_op", out_inst_op, 4);
        drain_one();

        // nop (rd = x0) never writes
        push_one(32'h00000013, 16'h0040);
        check("nop_we", out_reg_we, 0);
        check("nop_illegal", out_illegal, 0);
        drain_one();

        // branch funct3 010
        push_one(32'h00002063, 16'h0044);
        check("bad_branch_illegal", out_illegal, 1);
        drain_one();

        // streaming push+pop every cycle; order held across pointer wrap
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00000013;
        for (int k = 0; k < 5; k++) begin
            in_pc = 16'h0100 + 16'(k);
            tick();
            check("stream_pc", out_pc, 16'h0100 + 16'(k));
            check("stream_count", count, 1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("stream_drained", count, 0);

        // flush on a full queue with push and pop offered
        push_one(32'h00000013, 16'h0200);
        push_one(32'h00000013, 16'h0201);
        flush = 1'b1; in_valid = 1'b1; in_pc = 16'h0300; out_ready = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        check("flush_pc_zero", out_pc, 0);
        tick();
        check("flush_nothing_enq", count, 0);
        push_one(32'h00000013, 16'h0400);
        check("post_flush_pc", out_pc, 16'h0400);

        // reset while occupied
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", in_ready, 0);
        tick();
        check("rst_mid_count", count, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_pc", out_pc, 0);
        rst_n = 1'b1;
        tick();
        check("rst_mid_stays_empty", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
